framegen_bpp: RTL
=================

Name: framegen_bpp

Overview:
- Parametrised successor to the 1-bpp frame generator: scans a byte-wide framebuffer and emits 1, 2, 4 or 8 bits per pixel.
- Adds configurable active window position and size, optional vertical line doubling, and a border colour input.
- Sits between the hc/vc sync counters and the framebuffer read port (1-cycle synchronous read). Its pixel output feeds the palette/DAC stage.

Parameters:
- BPP, 1: bits per pixel; legal values 1, 2, 4, 8. PPB = 8/BPP pixels per byte.
- HSTART, 0: first active hc value.
- HACTIVE, 384: active pixels per line; must be a multiple of PPB.
- VSTART, 0: first active vc value.
- VACTIVE, 288: active output lines; must be even when VDOUBLE=1.
- VDOUBLE, 0: 1 = each source line is displayed on two consecutive output lines.
- ADDR_W, 14: framebuffer address width.
- BASE_ADDR, 0: address of the first byte of the frame.

Ports:
- clk7  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- hc  in  9  horizontal counter; increments by 1 every clk7 cycle within a line
- vc  in  9  vertical counter
- ram_addr  out  ADDR_W  framebuffer read address (registered)
- din  in  8  framebuffer data; equals mem[ram_addr] one cycle after the address is driven
- border_color  in  BPP  value output outside the active window
- pixel_out  out  BPP  current pixel (registered)
- active_out  out  1  pixel_out holds framebuffer data this cycle (registered)

Behaviour:
- Active region: HSTART <= hc < HSTART+HACTIVE and VSTART <= vc < VSTART+VACTIVE.
- Reset (rst=1 at a clk7 edge): ram_addr and line_base load BASE_ADDR; shifter, pixel_out and active_out load 0.
- Latency: exactly 2 cycles. pixel_out and active_out at cycle t correspond to the hc/vc presented at cycle t-2.
- Fetch: during the cycle where hc = HSTART + k*PPB on an active line, ram_addr holds the address of byte k. ram_addr increments at the end of that cycle.
- Load: the shifter loads din at the end of the following cycle. Pixels leave the shifter MSB-first, BPP bits per cycle, with the top BPP bits going to pixel_out.
- BPP=8: one fetch per cycle; the shifter degenerates to a register.
- Outside the active region, pixel_out = border_color and active_out = 0. Pipeline the active flag so there are no stale framebuffer bits at window edges.
- End of line: handled in the cycle with hc = HSTART+HACTIVE on an active line.
  - VDOUBLE=0, or the second copy of a line: line_base <= ram_addr, and ram_addr keeps its incremented value.
  - VDOUBLE=1 and the first copy (even (vc-VSTART)): ram_addr <= line_base, so the same source line is refetched.
- Frame restart: any cycle with vc outside [VSTART, VSTART+VACTIVE) sets ram_addr and line_base to BASE_ADDR. At least one non-active line per frame is required.
- Source bytes per frame: HACTIVE/PPB * VACTIVE, halved when VDOUBLE=1. ram_addr wraps modulo 2^ADDR_W; there is no overflow flag.
- Reset mid-frame: after rst deasserts, addressing restarts at BASE_ADDR.
  - Remaining active lines of that frame show the frame from its top.
  - Full alignment is restored at the first frame restart.
  - active_out is correct from 2 cycles after deassert.
- hc is not required to wrap at any particular value. The module only decodes the values defined above.

Test Plan:
- BPP=1, defaults, mem[0]=8'hA5 -> at vc=0, hc=0..7 input, pixel_out sequence 1,0,1,0,0,1,0,1 two cycles later; active_out=1; ram_addr=1 after hc=0.
- BPP=2, HSTART=3, mem[0]=8'h1B -> pixel_out 0,1,2,3 for hc=3..6 (+2 cycles); border_color=2'b10 on pixel_out for hc=0..2 and after hc=HSTART+HACTIVE-1.
- BPP=4, VDOUBLE=1, HACTIVE=8, VACTIVE=4 -> ram_addr sequences per line 0-3, 0-3, 4-7, 4-7; vc=4 resets ram_addr to BASE_ADDR=0.
- BPP=8, HACTIVE=4 -> ram_addr increments every cycle 0..3; pixel_out = mem[0..3] on consecutive cycles; line 1 starts at address 4.
- rst pulse at vc=100, hc=50 -> next cycle ram_addr=BASE_ADDR, pixel_out=0, active_out=0; next active fetch reads BASE_ADDR; the frame after next vblank is byte-exact against the reference model.
- ADDR_W=4, a frame needing 20 bytes -> ram_addr wraps 15->0 without stalling; reset to BASE_ADDR at vblank.

Source files
------------

// File: rtl/framegen_bpp.sv
// framegen_bpp
// Scans a byte-wide framebuffer in step with the external hc/vc sync
// counters. It emits 1, 2, 4 or 8 bits per pixel inside a configurable
// active window, and the border colour everywhere else. Lines can
// optionally be shown twice (vertical doubling).
//
// Ports
//   clk7          pixel clock
//   rst           synchronous reset, active-high
//   hc, vc        horizontal / vertical position counters (9 bit)
//   ram_addr      registered framebuffer read address
//   din           framebuffer data, mem[ram_addr] one cycle after the address
//   border_color  value shown outside the active window
//   pixel_out     registered pixel, two cycles behind hc/vc
//   active_out    registered flag: pixel_out carries framebuffer data
module framegen_bpp #(
   parameter int unsigned BPP       = 1,
   parameter int unsigned HSTART    = 0,
   parameter int unsigned HACTIVE   = 384,
   parameter int unsigned VSTART    = 0,
   parameter int unsigned VACTIVE   = 288,
   parameter int unsigned VDOUBLE   = 0,
   parameter int unsigned ADDR_W    = 14,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk7,
   input  logic              rst,
   input  logic [8:0]        hc,
   input  logic [8:0]        vc,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [7:0]        din,
   input  logic [BPP-1:0]    border_color,
   output logic [BPP-1:0]    pixel_out,
   output logic              active_out
);

   localparam int unsigned       PPB      = 8 / BPP;
   localparam logic [9:0]        H_BEGIN  = 10'(HSTART);
   localparam logic [9:0]        H_LEN    = 10'(HACTIVE);
   localparam logic [9:0]        V_BEGIN  = 10'(VSTART);
   localparam logic [9:0]        V_LEN    = 10'(VACTIVE);
   localparam logic [9:0]        PPB_MASK = 10'(PPB - 1);
   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

   logic [9:0]        hOff;
   logic [9:0]        vOff;
   logic              inLine;
   logic              pixActive;
   logic              fetch;
   logic              lineEnd;
   logic              firstCopy;

   logic [ADDR_W-1:0] ramAddr_q, ramAddr_d;
   logic [ADDR_W-1:0] lineBase_q, lineBase_d;
   logic [7:0]        shift_q, shift_d;
   logic [BPP-1:0]    pixel_q, pixel_d;
   logic              active_q, active_d;
   logic              act1_q, act1_d;
   logic              load1_q, load1_d;

   // Position decode. Offsets are taken relative to the window start in
   // 10 bits so a counter below the start wraps to a large value and a
   // single "offset < length" compare covers both window edges.
   always_comb begin
      hOff      = {1'b0, hc} - H_BEGIN;
      vOff      = {1'b0, vc} - V_BEGIN;
      inLine    = (vOff < V_LEN);
      pixActive = inLine && (hOff < H_LEN);
      fetch     = pixActive && ((hOff & PPB_MASK) == 10'd0);
      lineEnd   = inLine && (hOff == H_LEN);
      firstCopy = (vOff[0] == 1'b0);
   end

   // Address generation. Outside the active lines the address parks at
   // the frame base. At the end of a line either the next line's start is
   // remembered, or (first copy of a doubled line) the address rewinds so
   // the same source bytes are fetched again. Otherwise each fetch cycle
   // steps to the next byte, wrapping naturally at the address width.
   always_comb begin
      ramAddr_d  = ramAddr_q;
      lineBase_d = lineBase_q;
      if (!inLine) begin
         ramAddr_d  = BASE;
         lineBase_d = BASE;
      end else if (lineEnd) begin
         if ((VDOUBLE != 0) && firstCopy) begin
            ramAddr_d = lineBase_q;
         end else begin
            lineBase_d = ramAddr_q;
         end
      end else if (fetch) begin
         ramAddr_d = ramAddr_q + 1'b1;
      end
   end

   // Pixel pipeline. The active and fetch flags are delayed one cycle to
   // line up with din. On a fetch the first pixel comes straight from din
   // and the rest of the byte goes into the shifter. Other active cycles
   // drain the shifter MSB-first. Because the window flag travels down the
   // same pipeline, no leftover shifter bits appear at the window edges.
   always_comb begin
      act1_d   = pixActive;
      load1_d  = fetch;
      active_d = act1_q;
      shift_d  = shift_q;
      pixel_d  = border_color;
      if (act1_q) begin
         if (load1_q) begin
            pixel_d = din[7 -: BPP];
            shift_d = din << BPP;
         end else begin
            pixel_d = shift_q[7 -: BPP];
            shift_d = shift_q << BPP;
         end
      end
   end

   // State registers with synchronous reset. Reset drops the pipeline
   // flags as well, so no half-loaded byte is shown as active afterwards.
   always_ff @(posedge clk7) begin
      if (rst) begin
         ramAddr_q  <= BASE;
         lineBase_q <= BASE;
         shift_q    <= 8'd0;
         pixel_q    <= '0;
         active_q   <= 1'b0;
         act1_q     <= 1'b0;
         load1_q    <= 1'b0;
      end else begin
         ramAddr_q  <= ramAddr_d;
         lineBase_q <= lineBase_d;
         shift_q    <= shift_d;
         pixel_q    <= pixel_d;
         active_q   <= active_d;
         act1_q     <= act1_d;
         load1_q    <= load1_d;
      end
   end

   assign ram_addr   = ramAddr_q;
   assign pixel_out  = pixel_q;
   assign active_out = active_q;

endmodule
